seven_segment_capture: RTL

Receive-side companion to the four-digit multiplexed seven-segment driver: monitors the driver's `Cathode`/`Segment_out` pins, waits for each digit-select dwell to settle, and decodes the lit glyph back to a 4-bit hex value per digit. It sits beside the display driver in the FPGA top level, or in a bench harness, as a self-check and readback path. It produces a frame strobe when all four digits have been captured, and flags select conflicts, unknown glyphs and a stalled scan.

---
 rtl/seven_segment_capture.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/seven_segment_capture.sv
// -----------------------------------------------------------------------------
// seven_segment_capture
//
// Readback monitor for a four-digit multiplexed seven-segment driver. It
// watches the Cathode / Segment_out pins, waits until a select/segment pair
// has been stable for SETTLE edges, then decodes the lit glyph back to a hex
// nibble for the selected digit. A frame strobe fires once all four digits
// have been captured. Select conflicts, unknown glyphs and a stalled scan are
// flagged.
//
// Ports
//   clk          in   system clock, rising edge
//   RST          in   synchronous active-high reset
//   Cathode      in   [3:0] digit selects (bit i = digit i)
//   Segment_out  in   [6:0] segments, bit0=a .. bit6=g
//   digits       out  [15:0] decoded values, digit i at [4i+3:4i]
//   digit_seen   out  [3:0] digits captured in the current frame
//   frame_valid  out  one-cycle pulse when the fourth digit completes a frame
//   glyph_err    out  one-cycle pulse on a settled, unknown segment pattern
//   sel_err      out  one-cycle pulse on a settled multi-digit select
//   stall        out  level, no capture for STALL_CYCLES cycles
// -----------------------------------------------------------------------------
module seven_segment_capture #(
    parameter int SETTLE          = 2,
    parameter int STALL_CYCLES    = 1000,
    parameter bit CATH_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [3:0]  Cathode,
    input  logic [6:0]  Segment_out,
    output logic [15:0] digits,
    output logic [3:0]  digit_seen,
    output logic        frame_valid,
    output logic        glyph_err,
    output logic        sel_err,
    output logic        stall
);

    localparam int DW = $clog2(SETTLE + 1);
    localparam int SW = $clog2(STALL_CYCLES + 1);
    localparam logic [DW-1:0] SETTLE_W = DW'(SETTLE);
    localparam logic [SW-1:0] STALL_W  = SW'(STALL_CYCLES);

    // Returns {valid, value}; only exact glyph matches are accepted.
    function automatic logic [4:0] decode_glyph(input logic [6:0] p);
        case (p)
            7'h3F: decode_glyph = {1'b1, 4'h0};
            7'h06: decode_glyph = {1'b1, 4'h1};
            7'h5B: decode_glyph = {1'b1, 4'h2};
            7'h4F: decode_glyph = {1'b1, 4'h3};
            7'h66: decode_glyph = {1'b1, 4'h4};
            7'h6D: decode_glyph = {1'b1, 4'h5};
            7'h7D: decode_glyph = {1'b1, 4'h6};
            7'h07: decode_glyph = {1'b1, 4'h7};
            7'h7F: decode_glyph = {1'b1, 4'h8};
            7'h6F: decode_glyph = {1'b1, 4'h9};
            7'h77: decode_glyph = {1'b1, 4'hA};
            7'h7C: decode_glyph = {1'b1, 4'hB};
            7'h39: decode_glyph = {1'b1, 4'hC};
            7'h5E: decode_glyph = {1'b1, 4'hD};
            7'h79: decode_glyph = {1'b1, 4'hE};
            7'h71: decode_glyph = {1'b1, 4'hF};
            default: decode_glyph = 5'b0;
        endcase
    endfunction

    // Polarity-normalised, active-high select and segment pattern.
    logic [3:0] sel;
    logic [6:0] pat;
    assign sel = CATH_ACTIVE_LOW ? ~Cathode     : Cathode;
    assign pat = SEG_ACTIVE_LOW  ? ~Segment_out : Segment_out;

    logic [10:0]   pair_q,      pair_d;
    logic [DW-1:0] dwell_q,     dwell_d;
    logic          fire_q,      fire_d;
    logic [15:0]   digits_q,    digits_d;
    logic [3:0]    seen_q,      seen_d;
    logic          frame_q,     frame_d;
    logic          gerr_q,      gerr_d;
    logic          serr_q,      serr_d;
    logic [SW-1:0] stall_cnt_q, stall_cnt_d;

    logic       same;
    logic [3:0] ev_sel;
    logic [6:0] ev_pat;
    logic       ev_multi;
    logic       ev_onehot;
    logic [4:0] glyph;
    logic       capture;
    logic [3:0] seen_next;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        pair_d      = {sel, pat};
        same        = ({sel, pat} == pair_q);

        // Dwell length saturates at SETTLE; a change starts a new dwell at 1.
        if (!same)                 dwell_d = DW'(1);
        else if (dwell_q == SETTLE_W) dwell_d = dwell_q;
        else                       dwell_d = dwell_q + DW'(1);

        // Fire only on the edge the count first reaches SETTLE in this dwell.
        fire_d = (dwell_d == SETTLE_W) && !(same && (dwell_q == SETTLE_W));

        // The event is acted on one edge later, using the registered pair,
        // which still holds the dwell that fired.
        ev_sel    = pair_q[10:7];
        ev_pat    = pair_q[6:0];
        ev_multi  = (ev_sel & (ev_sel - 4'd1)) != 4'd0;
        ev_onehot = (ev_sel != 4'd0) && !ev_multi;
        glyph     = decode_glyph(ev_pat);
        capture   = fire_q && ev_onehot && glyph[4];
        seen_next = seen_q | ev_sel;

        digits_d = digits_q;
        seen_d   = seen_q;
        frame_d  = 1'b0;
        gerr_d   = 1'b0;
        serr_d   = 1'b0;

        if (fire_q) begin
            if (ev_multi) begin
                serr_d = 1'b1;
            end else if (ev_onehot) begin
                if (glyph[4]) begin
                    for (int i = 0; i < 4; i++) begin
                        if (ev_sel[i]) digits_d[4*i +: 4] = glyph[3:0];
                    end
                    if (seen_next == 4'b1111) begin
                        frame_d = 1'b1;
                        seen_d  = 4'b0000;
                    end else begin
                        seen_d  = seen_next;
                    end
                end else begin
                    gerr_d = 1'b1;
                end
            end
        end

        // Capture takes priority over saturation, so stall stays low.
        if (capture)                      stall_cnt_d = '0;
        else if (stall_cnt_q == STALL_W)  stall_cnt_d = stall_cnt_q;
        else                              stall_cnt_d = stall_cnt_q + SW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (RST) begin
            pair_q      <= '0;
            dwell_q     <= '0;
            fire_q      <= 1'b0;
            digits_q    <= '0;
            seen_q      <= '0;
            frame_q     <= 1'b0;
            gerr_q      <= 1'b0;
            serr_q      <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            pair_q      <= pair_d;
            dwell_q     <= dwell_d;
            fire_q      <= fire_d;
            digits_q    <= digits_d;
            seen_q      <= seen_d;
            frame_q     <= frame_d;
            gerr_q      <= gerr_d;
            serr_q      <= serr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign digits      = digits_q;
    assign digit_seen  = seen_q;
    assign frame_valid = frame_q;
    assign glyph_err   = gerr_q;
    assign sel_err     = serr_q;
    assign stall       = (stall_cnt_q == STALL_W);

endmodule
